// File: rtl/pwm_regs_mc.sv
// PWM register block: byte-wide bus into period/prescale/compare registers and per-channel controls.
// Define PWM_REGS_SHADOW_EN to double-buffer PERIOD/PRESCALE/COMPARE1/COMPARE2 until update_evt.
module pwm_regs_mc #(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                read,
    input  logic                write,
    input  logic [7:0]          addr,
    input  logic                high_byte,
    input  logic [7:0]          data_write,
    output logic [7:0]          data_read,
    input  logic [CW-1:0]       counter_val,
    input  logic                update_evt,
    output logic [CW-1:0]       period,
    output logic                en,
    output logic                count_reset,
    output logic                upnotdown,
    output logic [7:0]          prescale,
    output logic [NCH-1:0]      pwm_en,
    output logic [8*NCH-1:0]    functions,
    output logic [CW*NCH-1:0]   compare1,
    output logic [CW*NCH-1:0]   compare2,
    output logic                upd_pending
);

    function automatic logic [CW-1:0] put_byte(input logic [CW-1:0] cur, input logic hb,
                                               input logic [7:0] d);
        logic [15:0] w;
        w = 16'(cur);
        if (hb) w[15:8] = d;
        else    w[7:0]  = d;
        return CW'(w);
    endfunction

    function automatic logic [7:0] get_byte(input logic [CW-1:0] cur, input logic hb);
        logic [15:0] w;
        w = 16'(cur);
        return hb ? w[15:8] : w[7:0];
    endfunction

    logic [CW-1:0] period_a, period_b, period_n;
    logic [7:0]    prescale_a, prescale_b, prescale_n;
    logic [CW-1:0] cmp1_a [NCH];
    logic [CW-1:0] cmp1_b [NCH];
    logic [CW-1:0] cmp1_n [NCH];
    logic [CW-1:0] cmp2_a [NCH];
    logic [CW-1:0] cmp2_b [NCH];
    logic [CW-1:0] cmp2_n [NCH];
    logic [7:0]    func_r [NCH];
    logic [1:0]    cr_cnt;
    logic [CW-9:0] snap;
    logic [7:0]    ch_off;
    logic          ch_valid;
    logic          cr_wr;

    assign ch_off      = addr - 8'h10;
    assign ch_valid    = (addr >= 8'h10) && (int'(ch_off[7:2]) < NCH);
    assign cr_wr       = write && (addr == 8'h07) && data_write[0];
    assign count_reset = |cr_cnt;

    // Next value of every buffered register, with this cycle's write folded in.
    always_comb begin
        period_n   = period_b;
        prescale_n = prescale_b;
        if (write && addr == 8'h00) period_n = put_byte(period_b, high_byte, data_write);
        if (write && addr == 8'h0A) prescale_n = data_write;
        for (int unsigned c = 0; c < NCH; c++) begin
            cmp1_n[c] = cmp1_b[c];
            cmp2_n[c] = cmp2_b[c];
            if (write && ch_valid && ch_off[4:2] == 3'(c)) begin
                if (ch_off[1:0] == 2'd0) cmp1_n[c] = put_byte(cmp1_b[c], high_byte, data_write);
                if (ch_off[1:0] == 2'd1) cmp2_n[c] = put_byte(cmp2_b[c], high_byte, data_write);
            end
        end
    end

`ifdef PWM_REGS_SHADOW_EN
    logic [CW-1:0] period_p;
    logic [7:0]    prescale_p;
    logic [CW-1:0] cmp1_p [NCH];
    logic [CW-1:0] cmp2_p [NCH];
    logic          shadow_wr;
    logic          commit;

    assign shadow_wr = write && ((addr == 8'h00) || (addr == 8'h0A) || (ch_valid && !ch_off[1]));
    assign commit    = update_evt || cr_wr;

    always_comb begin
        period_b   = period_p;
        prescale_b = prescale_p;
        for (int unsigned c = 0; c < NCH; c++) begin
            cmp1_b[c] = cmp1_p[c];
            cmp2_b[c] = cmp2_p[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_p    <= '0;
            period_a    <= '0;
            prescale_p  <= '0;
            prescale_a  <= '0;
            upd_pending <= 1'b0;
            for (int unsigned c = 0; c < NCH; c++) begin
                cmp1_p[c] <= '0;
                cmp1_a[c] <= '0;
                cmp2_p[c] <= '0;
                cmp2_a[c] <= '0;
            end
        end else begin
            period_p   <= period_n;
            prescale_p <= prescale_n;
            for (int unsigned c = 0; c < NCH; c++) begin
                cmp1_p[c] <= cmp1_n[c];
                cmp2_p[c] <= cmp2_n[c];
            end
            if (commit) begin
                period_a    <= period_n;
                prescale_a  <= prescale_n;
                upd_pending <= 1'b0;
                for (int unsigned c = 0; c < NCH; c++) begin
                    cmp1_a[c] <= cmp1_n[c];
                    cmp2_a[c] <= cmp2_n[c];
                end
            end else if (shadow_wr) begin
                upd_pending <= 1'b1;
            end
        end
    end
`else
    logic evt_unused;
    assign evt_unused  = update_evt;
    assign upd_pending = 1'b0;

    always_comb begin
        period_b   = period_a;
        prescale_b = prescale_a;
        for (int unsigned c = 0; c < NCH; c++) begin
            cmp1_b[c] = cmp1_a[c];
            cmp2_b[c] = cmp2_a[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_a   <= '0;
            prescale_a <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                cmp1_a[c] <= '0;
                cmp2_a[c] <= '0;
            end
        end else begin
            period_a   <= period_n;
            prescale_a <= prescale_n;
            for (int unsigned c = 0; c < NCH; c++) begin
                cmp1_a[c] <= cmp1_n[c];
                cmp2_a[c] <= cmp2_n[c];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en        <= 1'b0;
            upnotdown <= 1'b1;
            cr_cnt    <= '0;
            snap      <= '0;
            pwm_en    <= '0;
            for (int unsigned c = 0; c < NCH; c++) func_r[c] <= '0;
        end else begin
            if (write && addr == 8'h02) en <= data_write[0];
            if (write && addr == 8'h0B) upnotdown <= data_write[0];
            if (cr_wr)               cr_cnt <= 2'd2;
            else if (cr_cnt != 2'd0) cr_cnt <= cr_cnt - 2'd1;
            if (read && addr == 8'h08 && !high_byte) snap <= counter_val[CW-1:8];
            for (int unsigned c = 0; c < NCH; c++) begin
                if (write && ch_valid && ch_off[4:2] == 3'(c)) begin
                    if (ch_off[1:0] == 2'd2) pwm_en[c] <= data_write[0];
                    if (ch_off[1:0] == 2'd3) func_r[c] <= data_write;
                end
            end
        end
    end

    always_comb begin
        data_read = '0;
        case (addr)
            8'h00:   data_read = get_byte(period_b, high_byte);
            8'h02:   data_read = {7'b0, en};
            8'h08:   data_read = high_byte ? 8'(snap) : counter_val[7:0];
            8'h0A:   data_read = prescale_b;
            8'h0B:   data_read = {7'b0, upnotdown};
            8'h0E:   data_read = {7'b0, upd_pending};
            default: data_read = '0;
        endcase
        for (int unsigned c = 0; c < NCH; c++) begin
            if (ch_valid && ch_off[4:2] == 3'(c)) begin
                case (ch_off[1:0])
                    2'd0:    data_read = get_byte(cmp1_b[c], high_byte);
                    2'd1:    data_read = get_byte(cmp2_b[c], high_byte);
                    2'd2:    data_read = {7'b0, pwm_en[c]};
                    default: data_read = func_r[c];
                endcase
            end
        end
    end

    always_comb begin
        period    = period_a;
        prescale  = prescale_a;
        functions = '0;
        compare1  = '0;
        compare2  = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            functions[8*c +: 8] = func_r[c];
            compare1[CW*c +: CW] = cmp1_a[c];
            compare2[CW*c +: CW] = cmp2_a[c];
        end
    end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// Directed bench for pwm_regs_mc: a default (NCH=4, CW=16) instance plus an NCH=2, CW=12 instance on the same bus.
module tb_pwm_regs_mc;

`ifdef PWM_REGS_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, read, write, high_byte, update_evt;
    logic [7:0]  addr, data_write;
    logic [15:0] counter_val;

    logic [7:0]  data_read, data_read12;
    logic [15:0] period;
    logic [11:0] period12;
    logic        en, count_reset, upnotdown, upd_pending;
    logic        en12, count_reset12, upnotdown12, upd_pending12;
    logic [7:0]  prescale, prescale12;
    logic [3:0]  pwm_en;
    logic [1:0]  pwm_en12;
    logic [31:0] functions;
    logic [15:0] functions12;
    logic [63:0] compare1, compare2;
    logic [23:0] compare1_12, compare2_12;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_regs_mc #(.NCH(4), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
        .high_byte(high_byte), .data_write(data_write), .data_read(data_read),
        .counter_val(counter_val), .update_evt(update_evt), .period(period), .en(en),
        .count_reset(count_reset), .upnotdown(upnotdown), .prescale(prescale),
        .pwm_en(pwm_en), .functions(functions), .compare1(compare1), .compare2(compare2),
        .upd_pending(upd_pending)
    );

    pwm_regs_mc #(.NCH(2), .CW(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
        .high_byte(high_byte), .data_write(data_write), .data_read(data_read12),
        .counter_val(counter_val[11:0]), .update_evt(update_evt), .period(period12), .en(en12),
        .count_reset(count_reset12), .upnotdown(upnotdown12), .prescale(prescale12),
        .pwm_en(pwm_en12), .functions(functions12), .compare1(compare1_12), .compare2(compare2_12),
        .upd_pending(upd_pending12)
    );

    task automatic do_write(input logic [7:0] a, input logic hb, input logic [7:0] d);
        @(negedge clk);
        addr = a; high_byte = hb; data_write = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic hb, output logic [7:0] v, output logic [7:0] v12);
        @(negedge clk);
        addr = a; high_byte = hb; read = 1'b1;
        #1 v = data_read; v12 = data_read12;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] v, v12;
        rst_n = 1'b0; read = 1'b0; write = 1'b0; addr = '0; high_byte = 1'b0;
        data_write = '0; counter_val = '0; update_evt = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (period !== 16'h0) begin errors++; $display("FAIL reset_period got=%h exp=0000", period); end
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", en); end
        checks++; if (count_reset !== 1'b0) begin errors++; $display("FAIL reset_count_reset got=%b exp=0", count_reset); end
        checks++; if (upnotdown !== 1'b1) begin errors++; $display("FAIL reset_upnotdown got=%b exp=1", upnotdown); end
        checks++; if (prescale !== 8'h0) begin errors++; $display("FAIL reset_prescale got=%h exp=00", prescale); end
        checks++; if (pwm_en !== 4'h0) begin errors++; $display("FAIL reset_pwm_en got=%h exp=0", pwm_en); end
        checks++; if (functions !== 32'h0) begin errors++; $display("FAIL reset_functions got=%h exp=0", functions); end
        checks++; if (compare1 !== 64'h0) begin errors++; $display("FAIL reset_compare1 got=%h exp=0", compare1); end
        checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL reset_upd_pending got=%b exp=0", upd_pending); end
        do_read(8'h0E, 1'b0, v, v12);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_status got=%h exp=00", v); end
    endtask

    task automatic test_period;
        logic [7:0] v, v12;
        do_write(8'h00, 1'b0, 8'h34);
        do_write(8'h00, 1'b1, 8'h12);
        checks++; if (period !== (SHADOW ? 16'h0000 : 16'h1234)) begin errors++; $display("FAIL period_before_update got=%h exp=%h", period, SHADOW ? 16'h0000 : 16'h1234); end
        checks++; if (upd_pending !== SHADOW) begin errors++; $display("FAIL period_upd_pending got=%b exp=%b", upd_pending, SHADOW); end
        do_read(8'h00, 1'b0, v, v12);
        checks++; if (v !== 8'h34) begin errors++; $display("FAIL period_read_lo got=%h exp=34", v); end
        do_read(8'h00, 1'b1, v, v12);
        checks++; if (v !== 8'h12) begin errors++; $display("FAIL period_read_hi got=%h exp=12", v); end
        @(negedge clk); update_evt = 1'b1;
        @(negedge clk); update_evt = 1'b0;
        checks++; if (period !== 16'h1234) begin errors++; $display("FAIL period_after_update got=%h exp=1234", period); end
        checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL period_pending_clear got=%b exp=0", upd_pending); end
    endtask

    task automatic test_count_reset;
        logic [7:0] v, v12;
        do_write(8'h0A, 1'b0, 8'h55);
        checks++; if (prescale !== (SHADOW ? 8'h00 : 8'h55)) begin errors++; $display("FAIL prescale_before got=%h exp=%h", prescale, SHADOW ? 8'h00 : 8'h55); end
        @(negedge clk); addr = 8'h07; high_byte = 1'b0; data_write = 8'h01; write = 1'b1;
        @(negedge clk); write = 1'b0;
        checks++; if (count_reset !== 1'b1) begin errors++; $display("FAIL cr_cycle1 got=%b exp=1", count_reset); end
        checks++; if (prescale !== 8'h55) begin errors++; $display("FAIL cr_forced_commit got=%h exp=55", prescale); end
        checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL cr_commit_pending got=%b exp=0", upd_pending); end
        @(negedge clk);
        checks++; if (count_reset !== 1'b1) begin errors++; $display("FAIL cr_cycle2 got=%b exp=1", count_reset); end
        write = 1'b1;
        @(negedge clk); write = 1'b0;
        checks++; if (count_reset !== 1'b1) begin errors++; $display("FAIL cr_restart1 got=%b exp=1", count_reset); end
        @(negedge clk);
        checks++; if (count_reset !== 1'b1) begin errors++; $display("FAIL cr_restart2 got=%b exp=1", count_reset); end
        @(negedge clk);
        checks++; if (count_reset !== 1'b0) begin errors++; $display("FAIL cr_end got=%b exp=0", count_reset); end
        do_write(8'h07, 1'b0, 8'h02);
        checks++; if (count_reset !== 1'b0) begin errors++; $display("FAIL cr_bit0_clear got=%b exp=0", count_reset); end
        do_read(8'h07, 1'b0, v, v12);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL cr_read got=%h exp=00", v); end
    endtask

    task automatic test_snapshot;
        @(negedge clk);
        counter_val = 16'h0AFF; addr = 8'h08; high_byte = 1'b0; read = 1'b1;
        #1;
        checks++; if (data_read !== 8'hFF) begin errors++; $display("FAIL snap_lo got=%h exp=FF", data_read); end
        @(negedge clk);
        counter_val = 16'h0B00; high_byte = 1'b1;
        #1;
        checks++; if (data_read !== 8'h0A) begin errors++; $display("FAIL snap_hi got=%h exp=0A", data_read); end
        checks++; if (data_read12 !== 8'h0A) begin errors++; $display("FAIL snap_hi_cw12 got=%h exp=0A", data_read12); end
        read = 1'b0;
    endtask

    task automatic test_channels;
        logic [7:0] v, v12;
        do_write(8'h02, 1'b0, 8'h01);
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL en_write got=%b exp=1", en); end
        do_write(8'h0B, 1'b0, 8'h00);
        checks++; if (upnotdown !== 1'b0) begin errors++; $display("FAIL upnotdown_write got=%b exp=0", upnotdown); end
        do_write(8'h1F, 1'b0, 8'h5A);
        checks++; if (functions !== 32'h5A00_0000) begin errors++; $display("FAIL ch3_functions got=%h exp=5A000000", functions); end
        do_write(8'h12, 1'b0, 8'h01);
        checks++; if (pwm_en !== 4'b0001) begin errors++; $display("FAIL ch0_pwm_en got=%b exp=0001", pwm_en); end
        do_write(8'h23, 1'b0, 8'h77);
        checks++; if (functions !== 32'h5A00_0000) begin errors++; $display("FAIL ch4_ignored got=%h exp=5A000000", functions); end
        do_read(8'h23, 1'b0, v, v12);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL ch4_read got=%h exp=00", v); end
        do_read(8'h1F, 1'b0, v, v12);
        checks++; if (v !== 8'h5A) begin errors++; $display("FAIL ch3_read got=%h exp=5A", v); end
        do_read(8'h05, 1'b0, v, v12);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL unmapped_read got=%h exp=00", v); end
    endtask

    task automatic test_cw12;
        logic [7:0] v, v12;
        do_write(8'h10, 1'b1, 8'hFF);
        do_read(8'h10, 1'b1, v, v12);
        checks++; if (v12 !== 8'h0F) begin errors++; $display("FAIL cw12_hi_read got=%h exp=0F", v12); end
        checks++; if (v !== 8'hFF) begin errors++; $display("FAIL cw16_hi_read got=%h exp=FF", v); end
        checks++; if (upd_pending12 !== SHADOW) begin errors++; $display("FAIL cw12_pending got=%b exp=%b", upd_pending12, SHADOW); end
        checks++; if (compare1_12[11:0] !== (SHADOW ? 12'h000 : 12'hF00)) begin errors++; $display("FAIL cw12_before got=%h exp=%h", compare1_12[11:0], SHADOW ? 12'h000 : 12'hF00); end
        @(negedge clk);
        addr = 8'h10; high_byte = 1'b0; data_write = 8'hAB; write = 1'b1; update_evt = 1'b1;
        @(negedge clk);
        write = 1'b0; update_evt = 1'b0;
        checks++; if (compare1_12[11:0] !== 12'hFAB) begin errors++; $display("FAIL cw12_coincident got=%h exp=FAB", compare1_12[11:0]); end
        checks++; if (upd_pending12 !== 1'b0) begin errors++; $display("FAIL cw12_pending_clear got=%b exp=0", upd_pending12); end
        checks++; if (compare1[15:0] !== 16'hFFAB) begin errors++; $display("FAIL cw16_coincident got=%h exp=FFAB", compare1[15:0]); end
        checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL cw16_pending_clear got=%b exp=0", upd_pending); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] v, v12;
        @(negedge clk); addr = 8'h07; high_byte = 1'b0; data_write = 8'h01; write = 1'b1;
        @(negedge clk); addr = 8'h0A; data_write = 8'h99;
        @(negedge clk); write = 1'b0;
        checks++; if (count_reset !== 1'b1) begin errors++; $display("FAIL mid_pulse_active got=%b exp=1", count_reset); end
        checks++; if (upd_pending !== SHADOW) begin errors++; $display("FAIL mid_pending got=%b exp=%b", upd_pending, SHADOW); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (count_reset !== 1'b0) begin errors++; $display("FAIL mid_count_reset got=%b exp=0", count_reset); end
        checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL mid_upd_pending got=%b exp=0", upd_pending); end
        checks++; if (period !== 16'h0) begin errors++; $display("FAIL mid_period got=%h exp=0000", period); end
        checks++; if (prescale !== 8'h0) begin errors++; $display("FAIL mid_prescale got=%h exp=00", prescale); end
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL mid_en got=%b exp=0", en); end
        checks++; if (upnotdown !== 1'b1) begin errors++; $display("FAIL mid_upnotdown got=%b exp=1", upnotdown); end
        checks++; if (functions !== 32'h0) begin errors++; $display("FAIL mid_functions got=%h exp=0", functions); end
        checks++; if (pwm_en !== 4'h0) begin errors++; $display("FAIL mid_pwm_en got=%h exp=0", pwm_en); end
        checks++; if (compare1 !== 64'h0) begin errors++; $display("FAIL mid_compare1 got=%h exp=0", compare1); end
        checks++; if (compare1_12 !== 24'h0) begin errors++; $display("FAIL mid_compare1_cw12 got=%h exp=0", compare1_12); end
        @(negedge clk); rst_n = 1'b1;
        do_read(8'h0A, 1'b0, v, v12);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL mid_prescale_read got=%h exp=00", v); end
        @(negedge clk);
        checks++; if (count_reset !== 1'b0) begin errors++; $display("FAIL mid_pulse_aborted got=%b exp=0", count_reset); end
    endtask

    initial begin
        test_reset;
        test_period;
        test_count_reset;
        test_snapshot;
        test_channels;
        test_cw12;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_regs_mc.md
PWM_REGS_MC -- requirements
Module: pwm_regs_mc

Interface
REQ-001 Parameter NCH, default 4, PWM channel count, legal range 1..8.
REQ-002 Parameter CW, default 16, counter/period/compare width, legal range 9..16.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 read  input  1  read strobe for current addr/high_byte.
REQ-006 write  input  1  write strobe, data_write captured on clk edge.
REQ-007 addr  input  8  register address.
REQ-008 high_byte  input  1  selects byte [15:8] (1) or [7:0] (0) of 16-bit registers.
REQ-009 data_write  input  8  write data.
REQ-010 data_read  output  8  read data, combinational from addr/high_byte.
REQ-011 counter_val  input  CW  live counter value from counter block.
REQ-012 update_evt  input  1  one-cycle period-boundary strobe from counter block.
REQ-013 period  output  CW  active period.
REQ-014 en  output  1  counter enable.
REQ-015 count_reset  output  1  counter reset pulse.
REQ-016 upnotdown  output  1  count direction, 1 = up.
REQ-017 prescale  output  8  active prescaler.
REQ-018 pwm_en  output  NCH  per-channel output enable.
REQ-019 functions  output  8*NCH  per-channel mode byte, channel c at [8c+7:8c].
REQ-020 compare1  output  CW*NCH  active compare1, channel c at [CW*c+CW-1:CW*c].
REQ-021 compare2  output  CW*NCH  active compare2, same packing.
REQ-022 upd_pending  output  1  shadow data awaiting commit.

Function
REQ-023 Global map SHALL be: 0x00 PERIOD, 0x02 EN, 0x07 COUNTER_RESET (write-only, reads 0), 0x08 COUNTER_VAL (read-only), 0x0A PRESCALE, 0x0B UPNOTDOWN, 0x0E STATUS (read-only, bit0 = upd_pending).
REQ-024 Channel c SHALL map at 0x10+4c: +0 COMPARE1, +1 COMPARE2, +2 PWM_EN (bit0), +3 FUNCTIONS; 16-bit registers byte-selected by high_byte.
REQ-025 Unmapped addresses, channels >= NCH, and writes to read-only registers SHALL be ignored on write and read 0x00.
REQ-026 High-byte bits at positions >= CW SHALL be discarded on write and read as 0.
REQ-027 Writes take effect at the clk edge where write=1; read=write=1 returns pre-write value on data_read.
REQ-028 PERIOD, PRESCALE, COMPARE1, COMPARE2 SHALL be double-buffered: writes update the pending copy and set upd_pending; reads return the pending copy.
REQ-029 On a clk edge with update_evt=1, all active copies SHALL load pending copies and upd_pending SHALL clear.
REQ-030 Write coinciding with update_evt: the written byte SHALL be included in the commit and upd_pending SHALL end 0.
REQ-031 EN, UPNOTDOWN, PWM_EN, FUNCTIONS SHALL take effect immediately (no shadow).
REQ-032 Write to 0x07 with data_write[0]=1 SHALL drive count_reset high for exactly 2 cycles from the next edge; a re-write while high SHALL restart the 2-cycle count; the same edge SHALL force a commit as in REQ-029.
REQ-033 Reading 0x08 low byte (read=1, high_byte=0) SHALL return live counter_val[7:0] and latch counter_val[CW-1:8] into a snapshot; reading 0x08 high byte SHALL return the snapshot.

Reset
REQ-034 On rst_n low, SHALL clear asynchronously: all pending/active registers 0, en 0, count_reset 0, snapshot 0, upd_pending 0, pwm_en 0, functions 0; upnotdown SHALL reset to 1.
REQ-035 Reset mid count_reset pulse or with pending data SHALL abort the pulse and discard pending data.

Configuration
REQ-036 Macro PWM_REGS_SHADOW_EN defined: REQ-028..REQ-030 and commit in REQ-032 apply.
REQ-037 Macro PWM_REGS_SHADOW_EN undefined: shadowed registers SHALL write active copies directly, upd_pending tied 0, update_evt ignored.

Verification
REQ-038 Write PERIOD low 0x34, high 0x12 -> period stays 0, upd_pending=1, read returns 0x1234; pulse update_evt -> period=0x1234, upd_pending=0.
REQ-039 Write 0x07 data 0x01 -> count_reset high exactly 2 cycles; re-write on 2nd high cycle -> high 2 further cycles.
REQ-040 counter_val=0x0AFF, read 0x08 low -> 0xFF; counter_val changes to 0x0B00, read 0x08 high -> 0x0A.
REQ-041 NCH=4: write 0x1F (ch3 FUNCTIONS) 0x5A -> functions[31:24]=0x5A immediately; write 0x23 (ch4) -> no change, reads 0x00.
REQ-042 CW=12: write COMPARE1 ch0 high 0xFF -> read returns 0x0F; write coincident with update_evt -> compare1 updates same edge, upd_pending=0.
REQ-043 Assert rst_n low during pending+pulse -> all outputs at reset values, upnotdown=1, within same cycle.
